// File: rtl/sap_1_ring_counter_decoder.sv
// SAP-1 timing and decode front end.
// Produces the one-hot T-state ring (T1..T6) and the one-hot instruction
// decode (LDA/ADD/SUB/OUT) that feed the control matrix. It also detects HLT
// in T4 and then freezes the sequencer until CLR. The ring either runs freely
// or advances once per debounced press of the STEP button.
module sap_1_ring_counter_decoder #(
    parameter logic [3:0] LDA_OP = 4'h0,
    parameter logic [3:0] ADD_OP = 4'h1,
    parameter logic [3:0] SUB_OP = 4'h2,
    parameter logic [3:0] OUT_OP = 4'hE,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] IR_OPCODE,
    input  logic       STEP_MODE,
    input  logic       STEP,
    output logic [6:1] ring_counter,
    output logic       LDA,
    output logic       ADD,
    output logic       SUB,
    output logic       OUT,
    output logic       HALTED
);

    localparam logic [6:1] T1 = 6'b000001;
    localparam logic [6:1] T4 = 6'b001000;

    // STEP synchronizer stages and the edge-detect delay stage
    logic       r_s1;
    logic       r_s2;
    logic       r_sd;

    // Sequencer state
    logic [6:1] r_ring;
    logic       r_halted;

    // Combinational helpers
    logic       w_step_pulse;
    logic       w_adv;
    logic       w_ring_legal;
    logic       w_hlt_hit;
    logic [6:1] w_ring_next;

    // Bring the asynchronous STEP level into CLK with two flops, then delay it one more
    // flop so that a rising edge can be turned into a single-cycle pulse.
    // NOTE: non-blocking assignments make each stage sample the previous stage's pre-edge
    // value, which is what gives a real shift chain instead of a single flop.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_sd <= 1'b0;
        end else begin
            r_s1 <= STEP;
            r_s2 <= r_s1;
            r_sd <= r_s2;
        end
    end

    // One advance per press: high only in the cycle after the synchronized level rises.
    // Holding the button down therefore gives exactly one step.
    assign w_step_pulse = r_s2 & ~r_sd;

    // In free run the ring advances every cycle. In step mode it advances only on the pulse.
    assign w_adv = ~STEP_MODE | w_step_pulse;

    // The ring is only rotated when it is legal. A corrupted multi-hot or all-zero value
    // restarts at T1 so that it never propagates.
    assign w_ring_legal = $onehot(r_ring);

    // HLT is only recognised in T4, where the control matrix would otherwise begin execution.
    assign w_hlt_hit = (r_ring == T4) && (IR_OPCODE == HLT_OP);

    // Next ring value on an advancing edge: rotate left with T6 wrapping to T1,
    // or recover to T1 when the current value is illegal.
    always_comb begin
        // NOTE: the default assignment comes first so that every path drives w_ring_next
        // and no latch can be inferred.
        w_ring_next = T1;
        if (w_ring_legal) begin
            w_ring_next = {r_ring[5:1], r_ring[6]};
        end
    end

    // Sequencer: CLR wins over everything. Once halted, the ring is frozen.
    // Otherwise, on an advance, either latch HLT (keeping T4) or move the ring.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_ring   <= T1;
            r_halted <= 1'b0;
        end else if (!r_halted && w_adv) begin
            if (w_hlt_hit) begin
                r_halted <= 1'b1;
            end else begin
                r_ring <= w_ring_next;
            end
        end
    end

    assign ring_counter = r_ring;
    assign HALTED       = r_halted;

    // Instruction decode is purely combinational. Unlisted opcodes, HLT included, leave
    // all four lines low, so T4..T6 behave as a NOP.
    assign LDA = (IR_OPCODE == LDA_OP);
    assign ADD = (IR_OPCODE == ADD_OP);
    assign SUB = (IR_OPCODE == SUB_OP);
    assign OUT = (IR_OPCODE == OUT_OP);

endmodule

// File: tb/tb_sap_1_ring_counter_decoder.sv
// Directed bench for the SAP-1 ring counter / decoder.
// Expected ring, HALTED and decode values are queued when each cycle's stimulus is set.
// They are popped and compared #1 after the following rising edge.
module tb_sap_1_ring_counter_decoder;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] IR_OPCODE;
    logic       STEP_MODE;
    logic       STEP;
    logic [6:1] ring_counter;
    logic       LDA;
    logic       ADD;
    logic       SUB;
    logic       OUT;
    logic       HALTED;

    typedef struct {
        string      tag;
        logic [6:1] ring;
        logic       halted;
        logic [3:0] dec;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    sap_1_ring_counter_decoder dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .IR_OPCODE    (IR_OPCODE),
        .STEP_MODE    (STEP_MODE),
        .STEP         (STEP),
        .ring_counter (ring_counter),
        .LDA          (LDA),
        .ADD          (ADD),
        .SUB          (SUB),
        .OUT          (OUT),
        .HALTED       (HALTED)
    );

    always #5 CLK = ~CLK;

    // Reference decode {LDA, ADD, SUB, OUT} for the default opcode map.
    function automatic logic [3:0] decode_model(input logic [3:0] op);
        case (op)
            4'h0:    return 4'b1000;
            4'h1:    return 4'b0100;
            4'h2:    return 4'b0010;
            4'hE:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_bits(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Queue the state expected after the next rising edge, given the inputs now applied.
    task automatic push_exp(input string tag, input logic [6:1] ring, input logic halted);
        exp_t e;
        e.tag    = tag;
        e.ring   = ring;
        e.halted = halted;
        e.dec    = decode_model(IR_OPCODE);
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check_bits({e.tag, ".ring"},   {2'b00, ring_counter},      {2'b00, e.ring});
            check_bits({e.tag, ".halted"}, {7'b0, HALTED},             {7'b0, e.halted});
            check_bits({e.tag, ".decode"}, {4'b0, LDA, ADD, SUB, OUT}, {4'b0, e.dec});
        end
    endtask

    // One clock: queue the expectation, let the edge happen, then compare away from the edge.
    task automatic cycle(input string tag, input logic [6:1] ring, input logic halted);
        push_exp(tag, ring, halted);
        @(posedge CLK);
        #1;
        pop_check();
    endtask

    initial begin
        logic [6:1] rot;

        // Reset
        CLR       = 1'b1;
        IR_OPCODE = 4'h1;
        STEP_MODE = 1'b0;
        STEP      = 1'b0;
        cycle("reset", 6'b000001, 1'b0);
        CLR = 1'b0;

        // Free-run rotation with ADD decoded throughout, including the T6 -> T1 wrap
        rot = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            rot = {rot[5:1], rot[6]};
            cycle($sformatf("rotate%0d", i), rot, 1'b0);
        end

        // HLT: freeze at T4 on the edge leaving T4
        IR_OPCODE = 4'hF;
        cycle("hlt_t2", 6'b000010, 1'b0);
        cycle("hlt_t3", 6'b000100, 1'b0);
        cycle("hlt_t4", 6'b001000, 1'b0);
        cycle("hlt_enter", 6'b001000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle($sformatf("hlt_hold%0d", i), 6'b001000, 1'b1);
        end
        IR_OPCODE = 4'h0;
        STEP_MODE = 1'b1;
        STEP      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("hlt_ignore%0d", i), 6'b001000, 1'b1);
        end
        STEP      = 1'b0;
        STEP_MODE = 1'b0;
        cycle("hlt_still", 6'b001000, 1'b1);
        CLR = 1'b1;
        cycle("hlt_clear", 6'b000001, 1'b0);
        CLR = 1'b0;

        // Single step: no press means no motion; a held press gives one advance two edges late
        STEP_MODE = 1'b1;
        IR_OPCODE = 4'h1;
        for (int i = 0; i < 10; i++) begin
            cycle($sformatf("step_idle%0d", i), 6'b000001, 1'b0);
        end
        STEP = 1'b1;
        cycle("step_k",   6'b000001, 1'b0);
        cycle("step_k1",  6'b000001, 1'b0);
        cycle("step_k2",  6'b000010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("step_held%0d", i), 6'b000010, 1'b0);
        end
        STEP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("step_release%0d", i), 6'b000010, 1'b0);
        end
        STEP_MODE = 1'b0;
        cycle("mode_free0", 6'b000100, 1'b0);
        cycle("mode_free1", 6'b001000, 1'b0);
        cycle("mode_free2", 6'b010000, 1'b0);

        // CLR at T5 with HLT present beats both advance and halt
        IR_OPCODE = 4'hF;
        CLR       = 1'b1;
        cycle("clr_priority", 6'b000001, 1'b0);
        CLR       = 1'b0;
        IR_OPCODE = 4'h1;

        // Illegal multi-hot value recovers to T1, then rotates normally
        cycle("seu_pre0", 6'b000010, 1'b0);
        cycle("seu_pre1", 6'b000100, 1'b0);
        #2;
        force dut.r_ring = 6'b010100;
        #1;
        release dut.r_ring;
        cycle("seu_recover", 6'b000001, 1'b0);
        cycle("seu_rotate",  6'b000010, 1'b0);

        // Decode sweep over every opcode
        for (int op = 0; op < 16; op++) begin
            logic [3:0] dec;
            IR_OPCODE = 4'(op);
            #1;
            dec = {LDA, ADD, SUB, OUT};
            check_bits($sformatf("sweep_op%0h", op), {4'b0, dec}, {4'b0, decode_model(4'(op))});
            check_bits($sformatf("sweep_single%0h", op), {7'b0, ($countones(dec) <= 1)}, 8'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
